// File: rtl/baccarat_pkg.sv
// Shared types, constants and helper functions for the baccarat card datapath.
package baccarat_pkg;

  typedef logic [3:0] rank_t;

  localparam rank_t       RANK_NONE = 4'd0;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Active-low seven-segment glyphs, bit 6 = segment g ... bit 0 = segment a.
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_J     = 7'b1100001;
  localparam logic [6:0] GLYPH_Q     = 7'b0011000;
  localparam logic [6:0] GLYPH_K     = 7'b0001001;

  function automatic logic [3:0] card_value(input rank_t r);
    return (r >= 4'd1 && r <= 4'd9) ? r : 4'd0;
  endfunction

  // Sum fits in 5 bits (max 27), so one subtraction of 10 or 20 reduces it.
  function automatic logic [3:0] score_mod10(input rank_t a, input rank_t b, input rank_t c);
    logic [4:0] s;
    s = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  function automatic logic [6:0] hex_glyph(input rank_t r);
    logic [6:0] g;
    case (r)
      4'd1:    g = GLYPH_A;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      4'd10:   g = GLYPH_0;
      4'd11:   g = GLYPH_J;
      4'd12:   g = GLYPH_Q;
      4'd13:   g = GLYPH_K;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/baccarat_datapath_card_dealer.sv
// Pseudo-random card source: free-running 16-bit Galois LFSR folded onto ranks 1..13.
module card_dealer
  import baccarat_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] new_card
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [3:0]  nib;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // Nibbles 13..15 wrap onto ranks 1..3.
  always_comb begin
    nib      = lfsr_q[3:0];
    new_card = (nib < 4'd13) ? nib + 4'd1 : nib - 4'd12;
  end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: card registers, scoring, win/tie tallies.
// Optional seven-segment outputs HEX0..HEX5 when BACCARAT_HEX_EN is defined.
module baccarat_datapath
  import baccarat_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TALLY_W   = 8
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               load_pcard1,
  input  logic               load_pcard2,
  input  logic               load_pcard3,
  input  logic               load_dcard1,
  input  logic               load_dcard2,
  input  logic               load_dcard3,
  input  logic               player_win_light,
  input  logic               dealer_win_light,
  output logic [3:0]         pcard1,
  output logic [3:0]         pcard2,
  output logic [3:0]         pcard3,
  output logic [3:0]         dcard1,
  output logic [3:0]         dcard2,
  output logic [3:0]         dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
`ifdef BACCARAT_HEX_EN
  ,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5
`endif
);

  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  rank_t       new_card;
  logic [5:0]  load;
  rank_t       cards_q [6];
  rank_t       cards_d [6];
  logic [1:0]  lights;
  logic [1:0]  lights_q;
  logic        lights_rise;
  logic [TALLY_W-1:0] pwins_q, pwins_d, dwins_q, dwins_d, ties_q, ties_d;

  card_dealer #(.LFSR_SEED(LFSR_SEED)) u_dealer (
    .clk      (slow_clock),
    .rst      (resetb),
    .new_card (new_card)
  );

  assign load = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

  // Index 0 is pcard1: loading it opens a new round and clears the other five.
  always_comb begin
    for (int i = 0; i < 6; i++) cards_d[i] = cards_q[i];
    if (load[0]) begin
      for (int i = 1; i < 6; i++) cards_d[i] = RANK_NONE;
    end
    for (int i = 0; i < 6; i++) begin
      if (load[i]) cards_d[i] = new_card;
    end
  end

  assign lights      = {player_win_light, dealer_win_light};
  assign lights_rise = (lights != 2'b00) && (lights_q == 2'b00);

  always_comb begin
    pwins_d = pwins_q;
    dwins_d = dwins_q;
    ties_d  = ties_q;
    if (lights_rise) begin
      case (lights)
        2'b10:   if (pwins_q != TALLY_MAX) pwins_d = pwins_q + TALLY_W'(1);
        2'b01:   if (dwins_q != TALLY_MAX) dwins_d = dwins_q + TALLY_W'(1);
        default: if (ties_q  != TALLY_MAX) ties_d  = ties_q  + TALLY_W'(1);
      endcase
    end
  end

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      for (int i = 0; i < 6; i++) cards_q[i] <= RANK_NONE;
      lights_q <= 2'b00;
      pwins_q  <= '0;
      dwins_q  <= '0;
      ties_q   <= '0;
    end else begin
      for (int i = 0; i < 6; i++) cards_q[i] <= cards_d[i];
      lights_q <= lights;
      pwins_q  <= pwins_d;
      dwins_q  <= dwins_d;
      ties_q   <= ties_d;
    end
  end

  assign pcard1      = cards_q[0];
  assign pcard2      = cards_q[1];
  assign pcard3      = cards_q[2];
  assign dcard1      = cards_q[3];
  assign dcard2      = cards_q[4];
  assign dcard3      = cards_q[5];
  assign pscore      = score_mod10(cards_q[0], cards_q[1], cards_q[2]);
  assign dscore      = score_mod10(cards_q[3], cards_q[4], cards_q[5]);
  assign player_wins = pwins_q;
  assign dealer_wins = dwins_q;
  assign ties        = ties_q;

`ifdef BACCARAT_HEX_EN
  logic [6:0] hex_q [6];
  logic [6:0] hex_d [6];

  always_comb begin
    for (int i = 0; i < 6; i++) hex_d[i] = hex_glyph(cards_q[i]);
  end

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= GLYPH_BLANK;
    end else begin
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
`endif

endmodule

// File: tb/tb_baccarat_datapath.sv
// Self-checking bench for baccarat_datapath against a behavioural table model.
module tb_baccarat_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ld  = 6'b0;
  logic [1:0] lt  = 2'b0;
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3, ps, ds;
  logic [3:0] pc1b, pc2b, pc3b, dc1b, dc2b, dc3b, psb, dsb;
  logic [7:0] pw, dw, ti;
  logic [1:0] pw2, dw2, ti2;
`ifdef BACCARAT_HEX_EN
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [6:0] g0, g1, g2, g3, g4, g5;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [15:0] m_lfsr;
  int          m_cards [6];
  int          m_pw, m_dw, m_ti;
  logic [1:0]  m_prev;

  always #5 clk = ~clk;

  baccarat_datapath dut (
    .slow_clock(clk), .resetb(rst),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .player_win_light(lt[1]), .dealer_win_light(lt[0]),
    .pcard1(pc1), .pcard2(pc2), .pcard3(pc3),
    .dcard1(dc1), .dcard2(dc2), .dcard3(dc3),
    .pscore(ps), .dscore(ds),
    .player_wins(pw), .dealer_wins(dw), .ties(ti)
`ifdef BACCARAT_HEX_EN
    , .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5)
`endif
  );

  baccarat_datapath #(.TALLY_W(2)) dut2 (
    .slow_clock(clk), .resetb(rst),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .player_win_light(lt[1]), .dealer_win_light(lt[0]),
    .pcard1(pc1b), .pcard2(pc2b), .pcard3(pc3b),
    .dcard1(dc1b), .dcard2(dc2b), .dcard3(dc3b),
    .pscore(psb), .dscore(dsb),
    .player_wins(pw2), .dealer_wins(dw2), .ties(ti2)
`ifdef BACCARAT_HEX_EN
    , .HEX0(g0), .HEX1(g1), .HEX2(g2), .HEX3(g3), .HEX4(g4), .HEX5(g5)
`endif
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x % 2 == 1) ? ((x / 2) ^ 16'hB400) : (x / 2);
  endfunction

  function automatic int model_rank(input logic [15:0] x);
    return (int'(x % 16) % 13) + 1;
  endfunction

  function automatic int hand_score(input int a, input int b, input int c);
    int v [3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) if (v[i] > 9) v[i] = 0;
    return (v[0] + v[1] + v[2]) % 10;
  endfunction

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_cards[i] = 0;
    m_pw = 0; m_dw = 0; m_ti = 0; m_prev = 2'b00;
  endtask

  // Called at a falling edge; applies inputs for one cycle and advances the model.
  task automatic drive_cycle(input logic [5:0] l, input logic [1:0] t);
    int r;
    r  = model_rank(m_lfsr);
    ld = l;
    lt = t;
    if (l[0]) for (int i = 1; i < 6; i++) m_cards[i] = 0;
    for (int i = 0; i < 6; i++) if (l[i]) m_cards[i] = r;
    if (t != 2'b00 && m_prev == 2'b00) begin
      if (t == 2'b10)      m_pw++;
      else if (t == 2'b01) m_dw++;
      else                 m_ti++;
    end
    m_prev = t;
    @(negedge clk);
  endtask

  task automatic load_card(input int idx, input int rank);
    for (int k = 0; k < 2000; k++) begin
      if (model_rank(m_lfsr) == rank) begin
        drive_cycle(6'(1 << idx), 2'b00);
        return;
      end
      drive_cycle(6'b0, 2'b00);
    end
    n_checks++; n_errors++;
    $display("FAIL load_card_timeout idx=%0d rank=%0d never dealt", idx, rank);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({pc1, pc2, pc3, dc1, dc2, dc3, ps, ds} !== 32'h0 || {pw, dw, ti} !== 24'h0) begin
      n_errors++;
      $display("FAIL reset_outputs cards=%h tallies=%h expected zero",
               {pc1, pc2, pc3, dc1, dc2, dc3, ps, ds}, {pw, dw, ti});
    end
    n_checks++;
    if (dut.u_dealer.lfsr_q !== 16'hACE1) begin
      n_errors++;
      $display("FAIL reset_lfsr got=%h expected=ace1", dut.u_dealer.lfsr_q);
    end
    model_clear();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dealer_sequence();
    int exp;
    for (int k = 0; k < 64; k++) begin
      exp = model_rank(m_lfsr);
      drive_cycle(6'b000010, 2'b00);
      n_checks++;
      if (int'(pc2) !== exp) begin
        n_errors++;
        $display("FAIL dealer_stream cycle=%0d got=%0d expected=%0d", k, pc2, exp);
      end
    end
    drive_cycle(6'b0, 2'b00);
    // Nibbles 12, 13 and 15 must deal K, A and 3.
    for (int j = 0; j < 3; j++) begin
      int nib, want;
      bit hit;
      nib  = (j == 0) ? 12 : (j == 1) ? 13 : 15;
      want = (j == 0) ? 13 : (j == 1) ? 1 : 3;
      hit  = 0;
      for (int k = 0; k < 2000 && !hit; k++) begin
        if (int'(m_lfsr % 16) == nib) begin
          drive_cycle(6'b000010, 2'b00);
          hit = 1;
        end else drive_cycle(6'b0, 2'b00);
      end
      n_checks++;
      if (!hit || int'(pc2) !== want) begin
        n_errors++;
        $display("FAIL dealer_nibble nib=%0d got=%0d expected=%0d", nib, pc2, want);
      end
    end
  endtask

  task automatic test_scores();
    load_card(0, 7);
    load_card(1, 8);
    n_checks++;
    if (ps !== 4'd5) begin
      n_errors++; $display("FAIL pscore_two_cards got=%0d expected=5", ps);
    end
    load_card(2, 13);
    n_checks++;
    if (ps !== 4'd5 || pc3 !== 4'd13) begin
      n_errors++; $display("FAIL pscore_three_cards got=%0d pcard3=%0d expected=5,13", ps, pc3);
    end
    load_card(3, 9);
    load_card(4, 12);
    n_checks++;
    if (ds !== 4'd9) begin
      n_errors++; $display("FAIL dscore got=%0d expected=9", ds);
    end
  endtask

  task automatic test_new_round_clear();
    drive_cycle(6'b111110, 2'b00);
    drive_cycle(6'b000001, 2'b00);
    n_checks++;
    if ({pc2, pc3, dc1, dc2, dc3, ds} !== 24'h0 || int'(pc1) !== m_cards[0] ||
        int'(ps) !== hand_score(m_cards[0], 0, 0)) begin
      n_errors++;
      $display("FAIL new_round_clear got=%h pcard1=%0d pscore=%0d expected others 0 pcard1=%0d",
               {pc2, pc3, dc1, dc2, dc3, ds}, pc1, ps, m_cards[0]);
    end
  endtask

  task automatic test_tallies();
    for (int k = 0; k < 3; k++) drive_cycle(6'b0, 2'b10);
    drive_cycle(6'b0, 2'b00);
    n_checks++;
    if (pw !== 8'd1 || dw !== 8'd0 || ti !== 8'd0) begin
      n_errors++; $display("FAIL tally_player_hold got=%0d/%0d/%0d expected=1/0/0", pw, dw, ti);
    end
    drive_cycle(6'b0, 2'b11);
    drive_cycle(6'b0, 2'b00);
    n_checks++;
    if (ti !== 8'd1) begin
      n_errors++; $display("FAIL tally_tie got=%0d expected=1", ti);
    end
    drive_cycle(6'b0, 2'b10);
    drive_cycle(6'b0, 2'b01);
    drive_cycle(6'b0, 2'b00);
    n_checks++;
    if (pw !== 8'd2 || dw !== 8'd0) begin
      n_errors++; $display("FAIL tally_no_gap got=%0d/%0d expected=2/0", pw, dw);
    end
    for (int k = 0; k < 5; k++) begin
      drive_cycle(6'b0, 2'b10);
      drive_cycle(6'b0, 2'b00);
    end
    n_checks++;
    if (pw2 !== 2'd3 || pw !== 8'd7) begin
      n_errors++; $display("FAIL tally_saturate got narrow=%0d wide=%0d expected=3,7", pw2, pw);
    end
  endtask

  task automatic test_random_rounds();
    logic [5:0] l;
    logic [1:0] t;
    t = 2'b00;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 6; i++) l[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) t = 2'($urandom_range(0, 3));
      drive_cycle(l, t);
      n_checks++;
      if (int'(pc1) !== m_cards[0] || int'(pc2) !== m_cards[1] || int'(pc3) !== m_cards[2] ||
          int'(dc1) !== m_cards[3] || int'(dc2) !== m_cards[4] || int'(dc3) !== m_cards[5] ||
          int'(ps) !== hand_score(m_cards[0], m_cards[1], m_cards[2]) ||
          int'(ds) !== hand_score(m_cards[3], m_cards[4], m_cards[5])) begin
        n_errors++;
        $display("FAIL random_cards cycle=%0d got=%0d,%0d,%0d,%0d,%0d,%0d s=%0d,%0d expected=%0d,%0d,%0d,%0d,%0d,%0d",
                 k, pc1, pc2, pc3, dc1, dc2, dc3, ps, ds,
                 m_cards[0], m_cards[1], m_cards[2], m_cards[3], m_cards[4], m_cards[5]);
      end
      n_checks++;
      if (int'(pw) !== sat(m_pw, 255) || int'(dw) !== sat(m_dw, 255) || int'(ti) !== sat(m_ti, 255) ||
          int'(pw2) !== sat(m_pw, 3) || int'(dw2) !== sat(m_dw, 3) || int'(ti2) !== sat(m_ti, 3)) begin
        n_errors++;
        $display("FAIL random_tallies cycle=%0d got=%0d,%0d,%0d narrow=%0d,%0d,%0d expected=%0d,%0d,%0d",
                 k, pw, dw, ti, pw2, dw2, ti2, m_pw, m_dw, m_ti);
      end
    end
    drive_cycle(6'b0, 2'b00);
  endtask

  task automatic test_reset_mid_round();
    drive_cycle(6'b111111, 2'b00);
    drive_cycle(6'b0, 2'b01);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({pc1, pc2, pc3, dc1, dc2, dc3, ps, ds} !== 32'h0 || {pw, dw, ti} !== 24'h0) begin
      n_errors++;
      $display("FAIL reset_mid_round cards=%h tallies=%h expected zero",
               {pc1, pc2, pc3, dc1, dc2, dc3, ps, ds}, {pw, dw, ti});
    end
    n_checks++;
    if (dut.u_dealer.lfsr_q !== 16'hACE1) begin
      n_errors++; $display("FAIL reset_mid_lfsr got=%h expected=ace1", dut.u_dealer.lfsr_q);
    end
    model_clear();
    @(negedge clk);
    ld = 6'b0; lt = 2'b00;
    rst = 1'b0;
    // Seed ACE1 has low nibble 1, so the first card after release is a 2.
    drive_cycle(6'b000010, 2'b00);
    n_checks++;
    if (pc2 !== 4'd2 || pc1 !== 4'd0) begin
      n_errors++; $display("FAIL first_card_after_reset got=%0d,%0d expected=0,2", pc1, pc2);
    end
  endtask

`ifdef BACCARAT_HEX_EN
  task automatic test_hex();
    load_card(0, 1);
    load_card(3, 12);
    drive_cycle(6'b0, 2'b00);
    n_checks++;
    if (h0 !== 7'b0001000 || h3 !== 7'b0011000 ||
        {h1, h2, h4, h5} !== 28'hFFFFFFF) begin
      n_errors++;
      $display("FAIL hex_glyphs got=%b %b %b %b %b %b expected A,blank,blank,q,blank,blank",
               h0, h1, h2, h3, h4, h5);
    end
  endtask
`endif

  initial begin
    test_reset();
    @(negedge clk);
    test_dealer_sequence();
    test_scores();
    test_new_round_clear();
    test_tallies();
    test_random_rounds();
    test_reset_mid_round();
`ifdef BACCARAT_HEX_EN
    test_hex();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
